// File: rtl/reg_file_param_if.sv
// Register file access bundle: one byte-enabled write port, two registered read ports.
// master drives write/read requests; slave returns read data, valids and addr_err.
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W   = DATA_W / 8;

  logic              write_en;
  logic [ADDR_W-1:0] write_adr;
  logic [BE_W-1:0]   write_be;
  logic [DATA_W-1:0] write_data;
  logic              read_en;
  logic [ADDR_W-1:0] read_adr1;
  logic [ADDR_W-1:0] read_adr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_valid1;
  logic              read_valid2;
  logic              addr_err;

  modport master (
    output write_en, write_adr, write_be, write_data,
    output read_en, read_adr1, read_adr2,
    input  read_data1, read_data2, read_valid1, read_valid2, addr_err
  );

  modport slave (
    input  write_en, write_adr, write_be, write_data,
    input  read_en, read_adr1, read_adr2,
    output read_data1, read_data2, read_valid1, read_valid2, addr_err
  );
endinterface

// File: rtl/reg_file_param.sv
// 2R1W register file: byte enables, write-first bypass, range check; ZERO_REG_EN hardwires entry 0 to zero.
// Reads return one cycle after read_en; no backpressure, a read and a write may be accepted every cycle.
module reg_file_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           reset,
  reg_file_param_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] adr);
    return ({1'b0, adr} < DEPTH_L);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] adr);
    return ZERO_REG && (adr == '0);
  endfunction

  logic              write_ok;
  logic [DATA_W-1:0] wr_cur;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_nxt1, rd_nxt2;
  logic              vld_nxt1, vld_nxt2;
  logic              err_nxt;

  always_comb begin
    write_ok = bus.write_en && in_range(bus.write_adr) && !is_zero(bus.write_adr);
    wr_cur   = in_range(bus.write_adr) ? mem[bus.write_adr] : '0;
    for (int b = 0; b < BE_W; b++) begin
      wr_merged[8*b +: 8] = bus.write_be[b] ? bus.write_data[8*b +: 8] : wr_cur[8*b +: 8];
    end
  end

  // Write-first: a read hitting the address being written sees the merged value.
  always_comb begin
    rd_nxt1  = '0;
    vld_nxt1 = 1'b0;
    rd_nxt2  = '0;
    vld_nxt2 = 1'b0;
    if (bus.read_en && in_range(bus.read_adr1)) begin
      vld_nxt1 = 1'b1;
      if (is_zero(bus.read_adr1))
        rd_nxt1 = '0;
      else if (write_ok && bus.read_adr1 == bus.write_adr)
        rd_nxt1 = wr_merged;
      else
        rd_nxt1 = mem[bus.read_adr1];
    end
    if (bus.read_en && in_range(bus.read_adr2)) begin
      vld_nxt2 = 1'b1;
      if (is_zero(bus.read_adr2))
        rd_nxt2 = '0;
      else if (write_ok && bus.read_adr2 == bus.write_adr)
        rd_nxt2 = wr_merged;
      else
        rd_nxt2 = mem[bus.read_adr2];
    end
    err_nxt = (bus.write_en && !in_range(bus.write_adr)) ||
              (bus.read_en && (!in_range(bus.read_adr1) || !in_range(bus.read_adr2)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.read_data1  <= '0;
      bus.read_data2  <= '0;
      bus.read_valid1 <= 1'b0;
      bus.read_valid2 <= 1'b0;
      bus.addr_err    <= 1'b0;
    end else begin
      if (write_ok) mem[bus.write_adr] <= wr_merged;
      bus.read_data1  <= rd_nxt1;
      bus.read_data2  <= rd_nxt2;
      bus.read_valid1 <= vld_nxt1;
      bus.read_valid2 <= vld_nxt2;
      bus.addr_err    <= err_nxt;
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a DEPTH=4 instance and a DEPTH=3 instance for range checks.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef ZERO_REG_EN
  localparam logic [15:0] R0_FFFF = 16'h0000;
  localparam logic [15:0] R0_1111 = 16'h0000;
`else
  localparam logic [15:0] R0_FFFF = 16'hFFFF;
  localparam logic [15:0] R0_1111 = 16'h1111;
`endif

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(16), .DEPTH(4)) bus4 ();
  reg_file_param_if #(.DATA_W(16), .DEPTH(3)) bus3 ();

  reg_file_param #(.DATA_W(16), .DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  reg_file_param #(.DATA_W(16), .DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set4(input logic we, input logic [1:0] wa, input logic [1:0] be,
                      input logic [15:0] wd, input logic re, input logic [1:0] a1, input logic [1:0] a2);
    bus4.write_en = we; bus4.write_adr = wa; bus4.write_be = be; bus4.write_data = wd;
    bus4.read_en = re; bus4.read_adr1 = a1; bus4.read_adr2 = a2;
  endtask

  task automatic set3(input logic we, input logic [1:0] wa, input logic [1:0] be,
                      input logic [15:0] wd, input logic re, input logic [1:0] a1, input logic [1:0] a2);
    bus3.write_en = we; bus3.write_adr = wa; bus3.write_be = be; bus3.write_data = wd;
    bus3.read_en = re; bus3.read_adr1 = a1; bus3.read_adr2 = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 2'd0, 2'd0);
    set3(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 2'd0, 2'd0);
    tick(); tick();
    check("rst_rd1", bus4.read_data1, 16'h0);
    check("rst_vld1", bus4.read_valid1, 1'b0);
    check("rst_vld2", bus4.read_valid2, 1'b0);
    check("rst_err", bus4.addr_err, 1'b0);
    reset = 1'b0;

    // Read r0 and r3 after reset
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd0, 2'd3);
    tick();
    check("init_rd1", bus4.read_data1, 16'h0000);
    check("init_rd2", bus4.read_data2, 16'h0000);
    check("init_vld1", bus4.read_valid1, 1'b1);
    check("init_vld2", bus4.read_valid2, 1'b1);

    // Write r2 = BEEF with no read: outputs idle
    set4(1'b1, 2'd2, 2'b11, 16'hBEEF, 1'b0, 2'd0, 2'd0);
    tick();
    check("idle_rd1", bus4.read_data1, 16'h0000);
    check("idle_vld1", bus4.read_valid1, 1'b0);
    check("idle_vld2", bus4.read_valid2, 1'b0);
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd2, 2'd2);
    tick();
    check("r2_rd1", bus4.read_data1, 16'hBEEF);
    check("r2_rd2", bus4.read_data2, 16'hBEEF);
    check("r2_vld2", bus4.read_valid2, 1'b1);

    // r1 = 1234, then upper-byte write of ABCD with bypass on port 1
    set4(1'b1, 2'd1, 2'b11, 16'h1234, 1'b0, 2'd0, 2'd0);
    tick();
    set4(1'b1, 2'd1, 2'b10, 16'hABCD, 1'b1, 2'd1, 2'd2);
    tick();
    check("byp_rd1", bus4.read_data1, 16'hAB34);
    check("byp_rd2", bus4.read_data2, 16'hBEEF);
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd1, 2'd1);
    tick();
    check("r1_rd1", bus4.read_data1, 16'hAB34);
    check("r1_rd2", bus4.read_data2, 16'hAB34);

    // write_be=0 leaves r2 alone; low-byte bypass on port 2 into r3
    set4(1'b1, 2'd2, 2'b00, 16'h0000, 1'b0, 2'd0, 2'd0);
    tick();
    set4(1'b1, 2'd3, 2'b01, 16'h12FF, 1'b1, 2'd2, 2'd3);
    tick();
    check("be0_rd1", bus4.read_data1, 16'hBEEF);
    check("byp2_rd2", bus4.read_data2, 16'h00FF);

    // Reset wins over a same-cycle write
    reset = 1'b1;
    set4(1'b1, 2'd3, 2'b11, 16'h5555, 1'b1, 2'd3, 2'd3);
    tick();
    check("rstw_vld1", bus4.read_valid1, 1'b0);
    check("rstw_rd1", bus4.read_data1, 16'h0000);
    reset = 1'b0;
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd3, 2'd2);
    tick();
    check("rstw_r3", bus4.read_data1, 16'h0000);
    check("rstw_r2", bus4.read_data2, 16'h0000);

    // Entry 0 behaviour (hardwired with ZERO_REG_EN)
    set4(1'b1, 2'd0, 2'b11, 16'hFFFF, 1'b0, 2'd0, 2'd0);
    tick();
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd0, 2'd0);
    tick();
    check("r0_rd1", bus4.read_data1, R0_FFFF);
    check("r0_rd2", bus4.read_data2, R0_FFFF);
    check("r0_vld1", bus4.read_valid1, 1'b1);
    set4(1'b1, 2'd0, 2'b11, 16'h1111, 1'b1, 2'd0, 2'd1);
    tick();
    check("r0_byp", bus4.read_data1, R0_1111);
    check("d4_err", bus4.addr_err, 1'b0);
    set4(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 2'd0, 2'd0);

    // DEPTH=3: out-of-range write/read
    set3(1'b1, 2'd2, 2'b11, 16'h2222, 1'b0, 2'd0, 2'd0);
    tick();
    set3(1'b1, 2'd3, 2'b11, 16'h7777, 1'b1, 2'd3, 2'd2);
    tick();
    check("oor_rd1", bus3.read_data1, 16'h0000);
    check("oor_vld1", bus3.read_valid1, 1'b0);
    check("oor_rd2", bus3.read_data2, 16'h2222);
    check("oor_vld2", bus3.read_valid2, 1'b1);
    check("oor_err", bus3.addr_err, 1'b1);
    set3(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd2, 2'd1);
    tick();
    check("oor_err_clr", bus3.addr_err, 1'b0);
    check("oor_keep_r2", bus3.read_data1, 16'h2222);
    check("oor_keep_r1", bus3.read_data2, 16'h0000);
    set3(1'b0, 2'd0, 2'b00, 16'h0, 1'b1, 2'd1, 2'd3);
    tick();
    check("oor_p2_err", bus3.addr_err, 1'b1);
    check("oor_p2_vld", bus3.read_valid2, 1'b0);
    check("oor_p1_vld", bus3.read_valid1, 1'b1);
    set3(1'b1, 2'd3, 2'b11, 16'h7777, 1'b0, 2'd0, 2'd0);
    tick();
    check("oor_w_err", bus3.addr_err, 1'b1);
    set3(1'b0, 2'd0, 2'b00, 16'h0, 1'b0, 2'd0, 2'd0);
    tick();
    check("oor_idle_err", bus3.addr_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
